// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - default binary width and displayed digit count
//   - internal scratch digit count (enough decimal digits for 2^W - 1)
//   - iteration counter width
//   - converter FSM state encoding
// ---------------------------------------------------------------------------
package bcd_pkg;

  localparam int W_DEF      = 32;
  localparam int DIGITS_DEF = 8;

  // ceil(w * log10(2)) using a fixed-point log10(2) = 0.30103.
  function automatic int int_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  // Counter must be able to hold the value w-1 (last shift index).
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int INT_DIGITS_DEF = int_digits(W_DEF);
  localparam int CNT_W_DEF      = cnt_width(W_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or
// more, so the following left shift carries correctly into the next digit.
// Ports:
//   din  in  4  current digit
//   dout out 4  corrected digit
// ---------------------------------------------------------------------------
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_bcd_seq
// Sequential signed binary to BCD converter (double-dabble, one bit per
// cycle). A conversion takes W shift cycles plus one DONE cycle; results are
// held stable on bcd/neg/ovf and only change together with the done pulse.
//
// Parameters:
//   W       binary input width (two's complement)
//   DIGITS  number of BCD digits presented on bcd
// Ports:
//   clk     in  1         clock, rising edge
//   rst     in  1         asynchronous active-high reset
//   start   in  1         conversion request, sampled only in IDLE
//   binary  in  W         signed value, captured on the accepting edge
//   busy    out 1         conversion in progress (SHIFT or DONE)
//   done    out 1         one-cycle pulse: new result on bcd/neg/ovf
//   neg     out 1         sign of last converted value
//   bcd     out 4*DIGITS  packed digits, units in [3:0]
//   ovf     out 1         magnitude did not fit in DIGITS digits
//
// Build option:
//   BCD_OVF_SAT_EN  defined: overflow saturates bcd to all nines, ovf=1.
//                   undefined: bcd is truncated to DIGITS digits, ovf=0.
// ---------------------------------------------------------------------------
module bin_bcd_seq
  import bcd_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        binary,
  output logic                busy,
  output logic                done,
  output logic                neg,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);

  localparam int NDIG  = int_digits(W);
  localparam int SW    = 4 * NDIG;
  localparam int CNT_W = cnt_width(W);

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [SW-1:0]       dig_q;
  logic [W-1:0]        mag_q;
  logic                neg_cap_q;

  logic [SW-1:0]       dig_adj;
  logic [SW+W-1:0]     shifted;
  logic [W-1:0]        mag_in;
  logic                last_shift;
  logic [4*DIGITS-1:0] low_digits;
  logic [4*DIGITS-1:0] res_bcd;

  // Two's complement magnitude; the most negative value maps onto itself,
  // which read as unsigned is exactly 2^(W-1).
  assign mag_in = binary[W-1] ? (~binary + 1'b1) : binary;

  for (genvar i = 0; i < NDIG; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (dig_q[i*4 +: 4]),
      .dout (dig_adj[i*4 +: 4])
    );
  end

  assign shifted    = {dig_adj, mag_q} << 1;
  assign last_shift = (cnt_q == CNT_W'(W - 1));

  if (DIGITS <= NDIG) begin : g_low_fit
    assign low_digits = dig_q[4*DIGITS-1:0];
  end else begin : g_low_pad
    assign low_digits = {{(4*(DIGITS-NDIG)){1'b0}}, dig_q};
  end

`ifdef BCD_OVF_SAT_EN
  logic upper_nz;
  logic ovf_q;

  if (NDIG > DIGITS) begin : g_upper
    assign upper_nz = |dig_q[SW-1:4*DIGITS];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  assign res_bcd = upper_nz ? {DIGITS{4'h9}} : low_digits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == DONE) begin
      ovf_q <= upper_nz;
    end
  end

  assign ovf = ovf_q;
`else
  assign res_bcd = low_digits;
  assign ovf     = 1'b0;
`endif

  // FSM state register.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values, regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d is defaulted before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Datapath: capture, shift, and result registers.
  // NOTE: the scratch register is reset along with the outputs so a
  // conversion aborted by rst leaves no stale digits behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      dig_q     <= '0;
      mag_q     <= '0;
      neg_cap_q <= 1'b0;
      done      <= 1'b0;
      neg       <= 1'b0;
      bcd       <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            neg_cap_q <= binary[W-1];
            mag_q     <= mag_in;
            dig_q     <= '0;
            cnt_q     <= '0;
          end
        end
        SHIFT: begin
          dig_q <= shifted[SW+W-1:W];
          mag_q <= shifted[W-1:0];
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          bcd  <= res_bcd;
          neg  <= neg_cap_q;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bin_bcd_seq.md
BIN_BCD_SEQ -- requirements
Module: bin_bcd_seq

Interface
REQ-001 SHALL have parameter W, default 32, binary input width (two's complement).
REQ-002 SHALL have parameter DIGITS, default 8, number of BCD digits presented to the displays.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  request a conversion of binary; sampled only in IDLE.
REQ-006 SHALL have port binary  in  W  signed value to convert; captured on the accepting edge.
REQ-007 SHALL have port busy  out  1  high while a conversion is in progress.
REQ-008 SHALL have port done  out  1  one-cycle pulse marking a new result on bcd/neg/ovf.
REQ-009 SHALL have port neg  out  1  sign of the last converted value.
REQ-010 SHALL have port bcd  out  4*DIGITS  packed digits, digit 0 (units) in bits [3:0]; feeds the 7-segment display drivers.
REQ-011 SHALL have port ovf  out  1  magnitude of last value exceeded DIGITS decimal digits.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 at edge E0: SHALL capture neg=binary[W-1] internally, magnitude=|binary| as W-bit unsigned (−2^(W−1) maps to 2^(W−1)), clear iteration counter, go to SHIFT.
REQ-014 SHIFT SHALL run exactly W cycles of double-dabble: every internal digit ≥5 gets +3, then the {digits, magnitude} register shifts left by 1.
REQ-015 Internal scratch SHALL hold ceil(W·log10(2)) digits (10 for W=32) so that overflow is detectable.
REQ-016 After the W-th shift (edge E0+W) SHALL enter DONE; at edge E0+W+1 SHALL register bcd, neg, ovf, assert done for exactly that cycle, and return to IDLE.
REQ-017 busy SHALL be 1 from the cycle after E0 through the DONE cycle inclusive; 0 in IDLE.
REQ-018 start while busy=1 SHALL be ignored, no queuing; binary changes after E0 SHALL not affect the result.
REQ-019 bcd/neg/ovf SHALL hold the previous result throughout a conversion (no display flicker) and change only with done.
REQ-020 Back-to-back: start held high SHALL begin the next conversion the cycle after DONE (IDLE accept), i.e., period W+2 cycles.

Reset
REQ-021 rst=1 SHALL immediately force state IDLE, busy=0, done=0, neg=0, ovf=0, bcd=0, counter and scratch to 0, independent of clk.
REQ-022 rst asserted mid-conversion SHALL abort it without a done pulse; first start after rst release is accepted normally.

Configuration
REQ-023 Macro BCD_OVF_SAT_EN defined: if any scratch digit above DIGITS-1 is nonzero, ovf=1 and bcd = all digits 9.
REQ-024 Macro BCD_OVF_SAT_EN undefined: bcd = lower DIGITS digits (truncation), ovf tied 0, upper-digit compare logic not built.

Structure
REQ-025 Shared package bcd_pkg SHALL hold default W/DIGITS constants, internal digit count, iteration-counter width and the FSM state enum.
REQ-026 Sub-module bcd_digit_adj (4-bit in, 4-bit out, +3 when ≥5) SHALL be instantiated once per internal digit.

Verification
REQ-027 rst, then start with binary=0 -> done at E0+33, bcd=0x00000000, neg=0, ovf=0, busy high 33 cycles.
REQ-028 binary=12345678 -> bcd=0x12345678, neg=0; binary=-1 (0xFFFFFFFF) -> bcd=0x00000001, neg=1.
REQ-029 binary=99999999 -> ovf=0, bcd=0x99999999; binary=100000000 -> with BCD_OVF_SAT_EN ovf=1, bcd=0x99999999; without, ovf=0, bcd=0x00000000.
REQ-030 binary=0x80000000 -> neg=1; with macro ovf=1, bcd=0x99999999; without, bcd=0x47483648.
REQ-031 start 12345678, re-pulse start with 55 at E0+10 -> ignored, result 0x12345678; new conversion, rst at E0+15 -> all outputs 0, no done, next start converts correctly.
REQ-032 start held high with constant binary=42 -> done pulses every 34 cycles, bcd=0x00000042 stable between pulses.
